// File: rtl/pwm_clock_gen.sv
// Multi-channel PWM clock generator: per-channel programmable period/high time,
// glitch-free start and end-of-period stop, shadowed configuration.
module pwm_clock_gen #(
  parameter int NCH = 2,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH*CW-1:0] cfg_period,
  input  logic [NCH*CW-1:0] cfg_high,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    period_tick,
  output logic [NCH-1:0]    running
);

  typedef enum logic {IDLE, RUN} state_e;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] per_q;
    logic [CW-1:0] high_q;
    logic          clk_q;
    logic          run_q;

    logic [CW-1:0] cfg_p;
    logic [CW-1:0] cfg_p_cl;
    logic [CW-1:0] cfg_h;
    logic [CW:0]   cnt_inc;
    logic          last;

    assign cfg_p    = cfg_period[g*CW +: CW];
    assign cfg_h    = cfg_high[g*CW +: CW];
    // Periods of 0 or 1 cannot toggle; clamp so the fastest output is clk/2.
    assign cfg_p_cl = (cfg_p < CW'(2)) ? CW'(2) : cfg_p;
    assign cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
    assign last     = (cnt_q == (per_q - CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        high_q  <= '0;
        clk_q   <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable[g]) begin
              state_q <= RUN;
              per_q   <= cfg_p_cl;
              high_q  <= cfg_h;
              cnt_q   <= '0;
              run_q   <= 1'b1;
              clk_q   <= (cfg_h != '0);
            end
          end
          RUN: begin
            if (last) begin
              cnt_q <= '0;
              if (enable[g]) begin
                per_q  <= cfg_p_cl;
                high_q <= cfg_h;
                clk_q  <= (cfg_h != '0);
              end else begin
                state_q <= IDLE;
                clk_q   <= 1'b0;
                run_q   <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_inc[CW-1:0];
              clk_q <= (cnt_inc < {1'b0, high_q});
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign clk_out[g]     = clk_q;
    assign running[g]     = run_q;
    assign period_tick[g] = run_q & last;
  end

endmodule

// File: tb/tb_pwm_clock_gen.sv
// Scoreboard bench for pwm_clock_gen: a period-level channel model predicts
// outputs per edge; a monitor compares them one cycle later.
module tb_pwm_clock_gen;
  localparam int NCH = 2;
  localparam int CW  = 8;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    enable;
  logic [NCH*CW-1:0] cfg_period;
  logic [NCH*CW-1:0] cfg_high;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    period_tick;
  logic [NCH-1:0]    running;

  pwm_clock_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_out(clk_out), .period_tick(period_tick), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] co;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] rn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: each channel is either inactive or at position pos of a period of
  // length P whose first H cycles are high.
  bit m_act[NCH];
  int m_pos[NCH];
  int m_P[NCH];
  int m_H[NCH];

  int p_v[NCH];
  int h_v[NCH];
  logic [NCH-1:0] en_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_P[i] = 0; m_H[i] = 0;
    end
  endtask

  task automatic model_edge(output exp_t e);
    for (int i = 0; i < NCH; i++) begin
      if (!m_act[i]) begin
        if (en_v[i]) begin
          m_act[i] = 1; m_pos[i] = 0;
          m_P[i] = (p_v[i] < 2) ? 2 : p_v[i];
          m_H[i] = h_v[i];
        end
      end else if (m_pos[i] == m_P[i] - 1) begin
        m_pos[i] = 0;
        if (en_v[i]) begin
          m_P[i] = (p_v[i] < 2) ? 2 : p_v[i];
          m_H[i] = h_v[i];
        end else begin
          m_act[i] = 0;
        end
      end else begin
        m_pos[i]++;
      end
      e.co[i] = m_act[i] && (m_pos[i] < m_H[i]);
      e.tk[i] = m_act[i] && (m_pos[i] == m_P[i] - 1);
      e.rn[i] = m_act[i];
    end
  endtask

  // Called 2 time units after a posedge: apply inputs, predict, advance.
  task automatic step(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      enable = en_v;
      for (int i = 0; i < NCH; i++) begin
        cfg_period[i*CW +: CW] = p_v[i][CW-1:0];
        cfg_high[i*CW +: CW]   = h_v[i][CW-1:0];
      end
      model_edge(e);
      q.push_back(e);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    model_reset();
    en_v = '0;
    enable = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst_running", 32'(running), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("clk_out", 32'(clk_out), 32'(e.co));
        chk("period_tick", 32'(period_tick), 32'(e.tk));
        chk("running", 32'(running), 32'(e.rn));
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; enable = '0; cfg_period = '0; cfg_high = '0;
    en_v = '0;
    for (int i = 0; i < NCH; i++) begin p_v[i] = 0; h_v[i] = 0; end
    model_reset();
    #3;
    chk("init_clk_out", 32'(clk_out), 32'd0);
    chk("init_tick", 32'(period_tick), 32'd0);
    chk("init_running", 32'(running), 32'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    step(2);

    // P=4 H=2 continuous
    p_v[0] = 4; h_v[0] = 2; en_v[0] = 1'b1;
    step(12);
    // retune mid-period (cnt=1): takes effect at the next wrap
    en_v[0] = 1'b0; step(4); en_v[0] = 1'b1;
    step(2);
    p_v[0] = 6; h_v[0] = 3;
    step(14);
    // duty/period edge cases
    p_v[0] = 5; h_v[0] = 0; step(15);
    p_v[0] = 4; h_v[0] = 7; step(12);
    p_v[0] = 1; h_v[0] = 1; step(10);
    p_v[0] = 0; h_v[0] = 0; step(6);
    // drop enable mid-period, then drop and re-assert before the wrap
    en_v[0] = 1'b0; step(6);
    p_v[0] = 8; h_v[0] = 4; en_v[0] = 1'b1; step(3);
    en_v[0] = 1'b0; step(12);
    en_v[0] = 1'b1; step(3);
    en_v[0] = 1'b0; step(4);
    en_v[0] = 1'b1; step(10);
    // async reset during the high phase
    p_v[0] = 8; h_v[0] = 6;
    step(3);
    do_reset();
    en_v[0] = 1'b1; step(10);
    // two channels enabled two cycles apart, then ch1 disabled
    en_v = '0; step(10);
    p_v[0] = 3; h_v[0] = 1; p_v[1] = 4; h_v[1] = 3;
    en_v[0] = 1'b1; step(2);
    en_v[1] = 1'b1; step(12);
    en_v[1] = 1'b0; step(12);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 15) == 0) en_v[i] = ~en_v[i];
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 9) == 0) begin
            p_v[i] = $urandom_range(0, 255);
            h_v[i] = $urandom_range(0, 255);
          end else begin
            p_v[i] = $urandom_range(0, 9);
            h_v[i] = $urandom_range(0, 11);
          end
        end
      end
      if (c == 700) do_reset();
      else step(1);
    end
    en_v = '0;
    step(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
